// File: rtl/poc_fifo_if.sv
// Register-bus and printer-port signal bundle for poc_fifo.
// The slave modport is the controller side; the master modport is the CPU/printer side.
interface poc_fifo_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              bus_wr;
  logic              bus_rd;
  logic [1:0]        bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              irq;
  logic              print_ready;
  logic [DATA_W-1:0] print_data;
  logic              pulse_request;

  modport master (
    output bus_wr, bus_rd, bus_addr, bus_wdata, print_ready,
    input  bus_rdata, irq, print_data, pulse_request
  );

  modport slave (
    input  bus_wr, bus_rd, bus_addr, bus_wdata, print_ready,
    output bus_rdata, irq, print_data, pulse_request
  );
endinterface

// File: rtl/poc_fifo.sv
// Printer output controller: bus-written FIFO drained to a printer port with
// a ready/pulse handshake, low-watermark interrupt and sticky overflow flag.
module poc_fifo #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP_W   = 1,
  parameter int unsigned LWM     = 2
) (
  input logic        clk,
  input logic        rst,
  poc_fifo_if.slave  bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  // Counter only ever holds CMAX-1.
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              ie;
  logic              ovf;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;

  logic              wr_ctrl, wr_stat, wr_data;
  logic              empty, full, busy;
  logic              push_ok, pop, flush;
  logic              irq_cond;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    wr_ctrl  = bus.bus_wr && (bus.bus_addr == 2'd0);
    wr_stat  = bus.bus_wr && (bus.bus_addr == 2'd1);
    wr_data  = bus.bus_wr && (bus.bus_addr == 2'd2);
    empty    = (level == '0);
    full     = (level == LW'(DEPTH));
    busy     = (state != IDLE);
    push_ok  = wr_data && !full;
    pop      = (state == IDLE) && !empty && bus.print_ready;
    flush    = wr_ctrl && bus.bus_wdata[1];
    irq_cond = ie && ((level <= LW'(LWM)) || ovf);
  end

  always_comb begin
    rd_val = '0;
    case (bus.bus_addr)
      2'd0:    rd_val[0]      = ie;
      2'd1:    rd_val[3:0]    = {ovf, busy, full, empty};
      2'd2:    rd_val         = '0;
      default: rd_val[LW-1:0] = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.bus_wdata;
    end
  end

  // Flush overrides any same-cycle push or pop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      level <= level + LW'(1);
      else if (pop && !push_ok) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie            <= 1'b0;
      ovf           <= 1'b0;
      bus.bus_rdata <= '0;
      bus.irq       <= 1'b1;
    end else begin
      if (bus.bus_rd) bus.bus_rdata <= rd_val;
      bus.irq <= !irq_cond;
      if (wr_ctrl) ie <= bus.bus_wdata[0];
      if (wr_data && full)               ovf <= 1'b1;
      else if (wr_stat && bus.bus_wdata[3]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.print_data    <= '0;
      bus.pulse_request <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.print_data    <= mem[rd_ptr];
            bus.pulse_request <= 1'b1;
            cnt               <= CW'(PULSE_W - 1);
            state             <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            bus.pulse_request <= 1'b0;
            if (GAP_W > 0) begin
              cnt   <= CW'(GAP_W - 1);
              state <= GAP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
